hazard_detection_unit: RTL and testbench

Pipeline hazard controller for the 5-stage RISC-V core, the stall/flush counterpart of the forwarding unit. It detects hazards that bypassing cannot resolve: load-use, ID-stage branch operands not yet produced, and data-memory wait. It sequences the required bubbles with a small FSM and down-counter. It drives PC, IF/ID and ID/EX control and sits beside the forwarding unit in the ID stage.

---
 rtl/hazard_detection_unit_pkg.sv | 43 ++++
 rtl/hazard_detection_unit_perf_counter.sv | 26 ++
 rtl/hazard_detection_unit.sv | 178 +++++++++++++++++
 tb/tb_hazard_detection_unit.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_detection_unit_pkg.sv
// Shared RISC-V definitions for the hazard detection unit.
//   - register address width default
//   - base opcode constants used for operand-use decode
//   - FSM state encodings for hazard_detection_unit
//   - decode_src_use(): which source register fields an opcode actually reads

`ifndef REG_ADDR_WIDTH
`define REG_ADDR_WIDTH 5
`endif

package hazard_detection_unit_pkg;

   localparam int HDU_REG_ADDR_WIDTH = `REG_ADDR_WIDTH;

   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_RTYPE  = 7'b0110011;

   typedef enum logic [1:0] {
      HDU_S_RUN      = 2'd0,
      HDU_S_STALL    = 2'd1,
      HDU_S_MEM_WAIT = 2'd2
   } hdu_state_e;

   // Returns {rs2_used, rs1_used}. Anything not listed (OP-IMM, SYSTEM, ...)
   // reads rs1 only.
   function automatic logic [1:0] decode_src_use(input logic [6:0] opcode);
      logic [1:0] use_bits;
      case (opcode)
         OPC_RTYPE, OPC_STORE, OPC_BRANCH: use_bits = 2'b11;
         OPC_LOAD, OPC_JALR:               use_bits = 2'b01;
         OPC_LUI, OPC_AUIPC, OPC_JAL:      use_bits = 2'b00;
         default:                          use_bits = 2'b01;
      endcase
      return use_bits;
   endfunction

endpackage

// File: rtl/hazard_detection_unit_perf_counter.sv
// hazard_perf_counter: 32-bit saturating event counter.
// Only compiled when HAZARD_PERF_CNT_EN is defined, since only then does
// hazard_detection_unit instantiate it.
//   clk     core clock
//   rst_n   synchronous active-low clear
//   inc_en  count this cycle
//   count   current value, sticks at 0xFFFF_FFFF

`ifdef HAZARD_PERF_CNT_EN
module hazard_perf_counter (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        inc_en,
   output logic [31:0] count
);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count <= '0;
      end else if (inc_en && (count != 32'hFFFF_FFFF)) begin
         count <= count + 32'd1;
      end
   end

endmodule
`endif

// File: rtl/hazard_detection_unit.sv
// hazard_detection_unit: stall/flush controller for the 5-stage RISC-V core.
// Detects load-use, ID-stage branch operand and data-memory-wait hazards and
// sequences bubbles with a small FSM plus a 2-bit remaining-bubble counter.
//
// Ports
//   clk, rst_n                 core clock, synchronous active-low reset
//   IF_ID_inst_opcode/rs1/rs2  instruction in ID
//   ID_EX_mem_rd_en/reg_wr_en/rd   instruction in EX
//   EX_MEM_mem_rd_en/rd        instruction in MEM
//   branch_taken               ID-stage redirect resolved taken
//   dmem_req, dmem_ready       data-memory handshake from MEM
//   pc_wr_en, IF_ID_wr_en      front-end advance enables
//   IF_ID_flush                squash IF/ID on taken redirect
//   ID_EX_bubble               insert NOP into ID/EX
//   pipe_freeze                hold EX/MEM and MEM/WB
//   stall_cycles, freeze_cycles, flush_count
//                              perf counters, present only with HAZARD_PERF_CNT_EN
//
// state          | meaning
// ---------------+-----------------------------------------------------------
// HDU_S_RUN      | hazard detect active; stall on hazard, flush on taken branch
// HDU_S_STALL    | extra bubbles pending; detect ignored, remaining counts down
// HDU_S_MEM_WAIT | whole pipe frozen on data memory; saved state/remaining kept

module hazard_detection_unit
   import hazard_detection_unit_pkg::*;
#(
   parameter int REG_ADDR_WIDTH = HDU_REG_ADDR_WIDTH
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [6:0]                IF_ID_inst_opcode,
   input  logic [REG_ADDR_WIDTH-1:0] IF_ID_rs1,
   input  logic [REG_ADDR_WIDTH-1:0] IF_ID_rs2,
   input  logic                      ID_EX_mem_rd_en,
   input  logic                      ID_EX_reg_wr_en,
   input  logic [REG_ADDR_WIDTH-1:0] ID_EX_rd,
   input  logic                      EX_MEM_mem_rd_en,
   input  logic [REG_ADDR_WIDTH-1:0] EX_MEM_rd,
   input  logic                      branch_taken,
   input  logic                      dmem_req,
   input  logic                      dmem_ready,
   output logic                      pc_wr_en,
   output logic                      IF_ID_wr_en,
   output logic                      IF_ID_flush,
   output logic                      ID_EX_bubble,
   output logic                      pipe_freeze
`ifdef HAZARD_PERF_CNT_EN
   ,
   output logic [31:0]               stall_cycles,
   output logic [31:0]               freeze_cycles,
   output logic [31:0]               flush_count
`endif
);

   hdu_state_e state, state_n;
   hdu_state_e saved_state, saved_state_n;
   hdu_state_e eff_state;
   logic [1:0] remaining, remaining_n;

   logic [1:0] src_use;
   logic       rs1_used, rs2_used, is_br;
   logic       match_ex, match_mem;
   logic       load_use, br_alu, br_load_ex, br_load_mem, hazard;
   logic [1:0] bubbles_m1;
   logic       frozen;

   assign src_use  = decode_src_use(IF_ID_inst_opcode);
   assign rs1_used = src_use[0];
   assign rs2_used = src_use[1];
   assign is_br    = (IF_ID_inst_opcode == OPC_BRANCH) || (IF_ID_inst_opcode == OPC_JALR);

   assign match_ex  = (rs1_used && (IF_ID_rs1 != '0) && (IF_ID_rs1 == ID_EX_rd)) ||
                      (rs2_used && (IF_ID_rs2 != '0) && (IF_ID_rs2 == ID_EX_rd));
   assign match_mem = (rs1_used && (IF_ID_rs1 != '0) && (IF_ID_rs1 == EX_MEM_rd)) ||
                      (rs2_used && (IF_ID_rs2 != '0) && (IF_ID_rs2 == EX_MEM_rd));

   assign load_use    = ID_EX_mem_rd_en && match_ex && !is_br;
   assign br_alu      = is_br && ID_EX_reg_wr_en && !ID_EX_mem_rd_en && match_ex;
   assign br_load_ex  = is_br && ID_EX_mem_rd_en && match_ex;
   assign br_load_mem = is_br && EX_MEM_mem_rd_en && match_mem;
   assign hazard      = load_use || br_alu || br_load_ex || br_load_mem;

   // A load still in EX feeding a branch needs two bubbles; everything else one.
   assign bubbles_m1 = br_load_ex ? 2'd1 : 2'd0;

   // Exit from the wait happens in the same cycle dmem_ready is seen, so a
   // ready cycle in S_MEM_WAIT already behaves like the saved state.
   assign frozen    = !dmem_ready && (dmem_req || (state == HDU_S_MEM_WAIT));
   assign eff_state = (state == HDU_S_MEM_WAIT) ? saved_state : state;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= HDU_S_RUN;
         saved_state <= HDU_S_RUN;
         remaining   <= 2'd0;
      end else begin
         state       <= state_n;
         saved_state <= saved_state_n;
         remaining   <= remaining_n;
      end
   end

   always_comb begin
      state_n       = state;
      saved_state_n = saved_state;
      remaining_n   = remaining;
      pc_wr_en      = 1'b1;
      IF_ID_wr_en   = 1'b1;
      IF_ID_flush   = 1'b0;
      ID_EX_bubble  = 1'b0;
      pipe_freeze   = 1'b0;

      if (frozen) begin
         state_n = HDU_S_MEM_WAIT;
         if (state != HDU_S_MEM_WAIT) begin
            saved_state_n = state;
         end
         pc_wr_en    = 1'b0;
         IF_ID_wr_en = 1'b0;
         pipe_freeze = 1'b1;
      end else begin
         case (eff_state)
            HDU_S_STALL: begin
               pc_wr_en     = 1'b0;
               IF_ID_wr_en  = 1'b0;
               ID_EX_bubble = 1'b1;
               remaining_n  = (remaining != 2'd0) ? (remaining - 2'd1) : 2'd0;
               state_n      = (remaining_n == 2'd0) ? HDU_S_RUN : HDU_S_STALL;
            end
            default: begin
               if (hazard) begin
                  pc_wr_en     = 1'b0;
                  IF_ID_wr_en  = 1'b0;
                  ID_EX_bubble = 1'b1;
                  remaining_n  = bubbles_m1;
                  state_n      = (bubbles_m1 != 2'd0) ? HDU_S_STALL : HDU_S_RUN;
               end else begin
                  state_n     = HDU_S_RUN;
                  IF_ID_flush = branch_taken;
               end
            end
         endcase
      end

      if (!rst_n) begin
         pc_wr_en     = 1'b0;
         IF_ID_wr_en  = 1'b0;
         IF_ID_flush  = 1'b0;
         ID_EX_bubble = 1'b1;
         pipe_freeze  = 1'b0;
      end
   end

`ifdef HAZARD_PERF_CNT_EN
   hazard_perf_counter u_stall_cnt (
      .clk    (clk),
      .rst_n  (rst_n),
      .inc_en (ID_EX_bubble),
      .count  (stall_cycles)
   );

   hazard_perf_counter u_freeze_cnt (
      .clk    (clk),
      .rst_n  (rst_n),
      .inc_en (pipe_freeze),
      .count  (freeze_cycles)
   );

   hazard_perf_counter u_flush_cnt (
      .clk    (clk),
      .rst_n  (rst_n),
      .inc_en (IF_ID_flush),
      .count  (flush_count)
   );
`endif

endmodule

// File: tb/tb_hazard_detection_unit.sv
// Scoreboard bench for hazard_detection_unit. Each cycle the expected
// {pc_wr_en, IF_ID_wr_en, IF_ID_flush, ID_EX_bubble, pipe_freeze} vector is
// queued with the stimulus and compared at the following negedge.

module tb_hazard_detection_unit;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;

   // {pc_wr_en, IF_ID_wr_en, IF_ID_flush, ID_EX_bubble, pipe_freeze}
   localparam logic [4:0] E_RUN    = 5'b11000;
   localparam logic [4:0] E_STALL  = 5'b00010;
   localparam logic [4:0] E_FLUSH  = 5'b11100;
   localparam logic [4:0] E_FREEZE = 5'b00001;
   localparam logic [4:0] E_RST    = 5'b00010;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [6:0] IF_ID_inst_opcode;
   logic [4:0] IF_ID_rs1, IF_ID_rs2;
   logic       ID_EX_mem_rd_en, ID_EX_reg_wr_en;
   logic [4:0] ID_EX_rd;
   logic       EX_MEM_mem_rd_en;
   logic [4:0] EX_MEM_rd;
   logic       branch_taken, dmem_req, dmem_ready;
   logic       pc_wr_en, IF_ID_wr_en, IF_ID_flush, ID_EX_bubble, pipe_freeze;
`ifdef HAZARD_PERF_CNT_EN
   logic [31:0] stall_cycles, freeze_cycles, flush_count;
`endif

   int n_checks = 0;
   int n_pass   = 0;
   logic [4:0] exp_q[$];

   always #5 clk = ~clk;

   hazard_detection_unit dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .IF_ID_inst_opcode (IF_ID_inst_opcode),
      .IF_ID_rs1         (IF_ID_rs1),
      .IF_ID_rs2         (IF_ID_rs2),
      .ID_EX_mem_rd_en   (ID_EX_mem_rd_en),
      .ID_EX_reg_wr_en   (ID_EX_reg_wr_en),
      .ID_EX_rd          (ID_EX_rd),
      .EX_MEM_mem_rd_en  (EX_MEM_mem_rd_en),
      .EX_MEM_rd         (EX_MEM_rd),
      .branch_taken      (branch_taken),
      .dmem_req          (dmem_req),
      .dmem_ready        (dmem_ready),
      .pc_wr_en          (pc_wr_en),
      .IF_ID_wr_en       (IF_ID_wr_en),
      .IF_ID_flush       (IF_ID_flush),
      .ID_EX_bubble      (ID_EX_bubble),
      .pipe_freeze       (pipe_freeze)
`ifdef HAZARD_PERF_CNT_EN
      ,
      .stall_cycles      (stall_cycles),
      .freeze_cycles     (freeze_cycles),
      .flush_count       (flush_count)
`endif
   );

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      IF_ID_inst_opcode = OP_IMM;
      IF_ID_rs1         = 5'd1;
      IF_ID_rs2         = 5'd2;
      ID_EX_mem_rd_en   = 1'b0;
      ID_EX_reg_wr_en   = 1'b0;
      ID_EX_rd          = 5'd0;
      EX_MEM_mem_rd_en  = 1'b0;
      EX_MEM_rd         = 5'd0;
      branch_taken      = 1'b0;
      dmem_req          = 1'b0;
      dmem_ready        = 1'b0;
   endtask

   task automatic set_id(input logic [6:0] op, input logic [4:0] rs1, input logic [4:0] rs2);
      IF_ID_inst_opcode = op;
      IF_ID_rs1         = rs1;
      IF_ID_rs2         = rs2;
   endtask

   task automatic set_ex(input logic ld, input logic wr, input logic [4:0] rd);
      ID_EX_mem_rd_en = ld;
      ID_EX_reg_wr_en = wr;
      ID_EX_rd        = rd;
   endtask

   // Inputs are already applied (just after a posedge); queue the expectation,
   // sample at negedge, then move to just after the next posedge.
   task automatic cyc(input string tag, input logic [4:0] exp);
      logic [4:0] obs;
      exp_q.push_back(exp);
      @(negedge clk);
      obs = {pc_wr_en, IF_ID_wr_en, IF_ID_flush, ID_EX_bubble, pipe_freeze};
      check_eq(tag, {27'd0, obs}, {27'd0, exp_q.pop_front()});
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      idle();
      rst_n = 1'b0;
      cyc("reset_0", E_RST);
      cyc("reset_1", E_RST);
      rst_n = 1'b1;
      cyc("run_idle", E_RUN);

      // load-use: lw x5 in EX, add x6,x5,x1 in ID
      set_ex(1'b1, 1'b1, 5'd5); set_id(OP_RTYPE, 5'd5, 5'd1);
      cyc("load_use_stall", E_STALL);
      set_ex(1'b0, 1'b0, 5'd0);
      cyc("load_use_after", E_RUN);

      // store data operand (rs2) also counts
      set_ex(1'b1, 1'b1, 5'd5); set_id(OP_STORE, 5'd2, 5'd5);
      cyc("store_rs2_stall", E_STALL);
      // opcodes that do not read the matching field
      set_id(OP_IMM, 5'd1, 5'd5);
      cyc("opimm_rs2_unused", E_RUN);
      set_id(OP_LUI, 5'd5, 5'd0);
      cyc("lui_rs1_unused", E_RUN);
      set_id(OP_JAL, 5'd5, 5'd5);
      cyc("jal_unused", E_RUN);
      idle();

      // lw x5 in EX, beq x5,x0 in ID: two stalls, taken ignored until RUN
      set_ex(1'b1, 1'b1, 5'd5); set_id(OP_BRANCH, 5'd5, 5'd0);
      cyc("br_load_ex_c0", E_STALL);
      set_ex(1'b0, 1'b0, 5'd0); branch_taken = 1'b1;
      cyc("br_load_ex_c1", E_STALL);
      cyc("br_load_ex_c2_flush", E_FLUSH);
      branch_taken = 1'b0;
      cyc("br_load_ex_done", E_RUN);

      // add x7 in EX, bne x7,x2 in ID
      set_ex(1'b0, 1'b1, 5'd7); set_id(OP_BRANCH, 5'd7, 5'd2);
      cyc("br_alu_stall", E_STALL);
      set_ex(1'b0, 1'b0, 5'd0);
      cyc("br_alu_after", E_RUN);
      set_ex(1'b0, 1'b1, 5'd0);
      cyc("br_alu_rd0", E_RUN);
      set_id(OP_BRANCH, 5'd0, 5'd2);
      cyc("br_alu_x0", E_RUN);

      // load in MEM feeding JALR
      idle();
      EX_MEM_mem_rd_en = 1'b1; EX_MEM_rd = 5'd3; set_id(OP_JALR, 5'd3, 5'd0);
      cyc("br_load_mem_stall", E_STALL);
      EX_MEM_mem_rd_en = 1'b0;
      cyc("br_load_mem_after", E_RUN);

      // taken branch, no hazard
      set_id(OP_BRANCH, 5'd1, 5'd2); branch_taken = 1'b1;
      cyc("flush", E_FLUSH);
      branch_taken = 1'b0;
      cyc("flush_done", E_RUN);

      // memory wait during S_STALL with remaining=1
      set_ex(1'b1, 1'b1, 5'd5); set_id(OP_BRANCH, 5'd5, 5'd0);
      cyc("mw_stall_entry", E_STALL);
      set_ex(1'b0, 1'b0, 5'd0); dmem_req = 1'b1; dmem_ready = 1'b0;
      cyc("mw_freeze_0", E_FREEZE);
      cyc("mw_freeze_1", E_FREEZE);
      cyc("mw_freeze_2", E_FREEZE);
      dmem_ready = 1'b1;
      cyc("mw_resume_stall", E_STALL);
      dmem_req = 1'b0; dmem_ready = 1'b0;
      cyc("mw_resume_run", E_RUN);

      // one-cycle wait from RUN; freeze beats hazard and flush
      idle();
      dmem_req = 1'b1; branch_taken = 1'b1;
      set_ex(1'b1, 1'b1, 5'd4); set_id(OP_RTYPE, 5'd4, 5'd1);
      cyc("mw_prio_freeze", E_FREEZE);
      dmem_ready = 1'b1;
      cyc("mw_exit_hazard", E_STALL);
      idle();
      cyc("mw_exit_run", E_RUN);

      // reset while in S_MEM_WAIT
      dmem_req = 1'b1;
      cyc("rst_mw_freeze_0", E_FREEZE);
      cyc("rst_mw_freeze_1", E_FREEZE);
      rst_n = 1'b0;
      cyc("rst_mw_low", E_RST);
      rst_n = 1'b1; dmem_req = 1'b0;
      cyc("rst_mw_run", E_RUN);

      // reset mid-stall discards the pending bubble
      set_ex(1'b1, 1'b1, 5'd5); set_id(OP_BRANCH, 5'd5, 5'd0);
      cyc("rst_st_entry", E_STALL);
      idle(); rst_n = 1'b0;
      cyc("rst_st_low", E_RST);
`ifdef HAZARD_PERF_CNT_EN
      cyc("rst_st_low2", E_RST);
      check_eq("perf_stall_rst", stall_cycles, 32'd0);
      check_eq("perf_freeze_rst", freeze_cycles, 32'd0);
      check_eq("perf_flush_rst", flush_count, 32'd0);
`endif
      rst_n = 1'b1;
      cyc("rst_st_run", E_RUN);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
